// File: rtl/clk_div_n.sv
// Runtime-programmable integer clock divider with 50% duty for odd and even divisors.
// Optional run enable (en_i) and parking behaviour are compiled in with `define CLK_DIV_STOP_EN.
module clk_div_n #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DIV_DEFAULT = 5
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [CNT_W-1:0] div_n_i,
    input  logic             div_load_i,
`ifdef CLK_DIV_STOP_EN
    input  logic             en_i,
`endif
    output logic             clk_out_o,
    output logic             tick_o,
    output logic [CNT_W-1:0] div_active_o,
    output logic             div_err_o
);

    localparam longint unsigned DivLimit = 64'd1 << CNT_W;
    localparam logic [CNT_W-1:0] DivRst  = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] CntRst  = CNT_W'(DIV_DEFAULT - 1);
    localparam logic [CNT_W-1:0] One     = CNT_W'(1);
    localparam logic [CNT_W-1:0] Two     = CNT_W'(2);

    // Reject a reset divisor that cannot be represented or cannot toggle.
    if (DIV_DEFAULT < 2 || 64'(DIV_DEFAULT) >= DivLimit) begin : g_bad_default
        $error("clk_div_n: DIV_DEFAULT must be >= 2 and < 2**CNT_W");
    end

    logic             run;
`ifdef CLK_DIV_STOP_EN
    assign run = en_i;
`else
    assign run = 1'b1;
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             p_q, p_d;
    logic             q_q;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic             wrap;
    logic             park;
    logic             apply;
    logic             load_ok;

    // Next-state: counter, divisor hand-over at the period boundary, phase and strobes.
    always_comb begin
        cnt_d      = cnt_q;
        n_d        = n_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        p_d        = 1'b0;
        tick_d     = 1'b0;
        err_d      = 1'b0;

        wrap    = (cnt_q == (n_q - One));
        park    = wrap & ~run;
        apply   = wrap & run & pend_vld_q;
        load_ok = div_load_i & (div_n_i >= Two);

        if (wrap) begin
            if (run) begin
                cnt_d = '0;
            end
        end else begin
            cnt_d = cnt_q + One;
        end

        if (apply) begin
            n_d        = pend_q;
            pend_vld_d = 1'b0;
        end

        // A load on the apply edge itself waits for the following boundary.
        if (load_ok) begin
            pend_d     = div_n_i;
            pend_vld_d = 1'b1;
        end

        err_d = div_load_i & ~(div_n_i >= Two);

        if (!park) begin
            p_d    = (cnt_d < (n_d >> 1));
            tick_d = (cnt_d == '0);
        end
    end

    // Posedge state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q      <= CntRst;
            n_q        <= DivRst;
            pend_q     <= DivRst;
            pend_vld_q <= 1'b0;
            p_q        <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            p_q        <= p_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    // Half-cycle extension of the high phase for odd divisors.
    always_ff @(negedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= p_q & n_q[0];
        end
    end

    assign clk_out_o    = p_q | q_q;
    assign tick_o       = tick_q;
    assign div_active_o = n_q;
    assign div_err_o    = err_q;

endmodule

// File: tb/tb_clk_div_n.sv
// Self-checking bench for clk_div_n: directed vector table, corner sequences and
// randomized loads checked against a half-cycle slot model of the output waveform.
module tb_clk_div_n;

    localparam int unsigned CNT_W = 8;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic [CNT_W-1:0] div_n_i;
    logic             div_load_i;
    logic             en_r;
    logic             clk_out_o;
    logic             tick_o;
    logic [CNT_W-1:0] div_active_o;
    logic             div_err_o;

    clk_div_n #(.CNT_W(CNT_W), .DIV_DEFAULT(5)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .div_n_i      (div_n_i),
        .div_load_i   (div_load_i),
`ifdef CLK_DIV_STOP_EN
        .en_i         (en_r),
`endif
        .clk_out_o    (clk_out_o),
        .tick_o       (tick_o),
        .div_active_o (div_active_o),
        .div_err_o    (div_err_o)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    // Model: a period of N cycles is 2N half-cycle slots; clk_out is high in slots 0..N-1.
    int m_n, m_pos, m_pend;
    bit m_pvld, m_err;

    logic act_hi, act_lo, act_tick;

    typedef struct {
        logic       ld;
        logic [7:0] dn;
        logic       hi;
        logic       lo;
        logic       tk;
        logic [7:0] act;
        logic       err;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_n    = 5;
        m_pos  = 4;
        m_pend = 0;
        m_pvld = 1'b0;
        m_err  = 1'b0;
    endfunction

    function automatic void model_edge(input logic ld, input int dn, input logic en);
        if (m_pos == m_n - 1) begin
            if (en) begin
                if (m_pvld) begin
                    m_n    = m_pend;
                    m_pvld = 1'b0;
                end
                m_pos = 0;
            end
        end else begin
            m_pos++;
        end
        if (ld && dn >= 2) begin
            m_pend = dn;
            m_pvld = 1'b1;
        end
        m_err = ld && (dn < 2);
    endfunction

    // One sys_clk cycle: inputs set before the posedge, outputs sampled after each edge.
    task automatic step(input logic ld, input logic [7:0] dn, input logic en);
        div_load_i = ld;
        div_n_i    = dn;
        en_r       = en;
        @(posedge sys_clk);
        model_edge(ld, int'(dn), en);
        #1;
        act_hi   = clk_out_o;
        act_tick = tick_o;
        chk("clk_first_half", 32'(act_hi), 32'(2 * m_pos < m_n));
        chk("tick", 32'(act_tick), 32'(m_pos == 0));
        chk("div_active", 32'(div_active_o), 32'(m_n));
        chk("div_err", 32'(div_err_o), 32'(m_err));
        @(negedge sys_clk);
        #1;
        act_lo = clk_out_o;
        chk("clk_second_half", 32'(act_lo), 32'(2 * m_pos + 1 < m_n));
        div_load_i = 1'b0;
    endtask

    task automatic align();
        for (int i = 0; i < 600 && m_pos != m_n - 1; i++) step(1'b0, 8'd0, 1'b1);
    endtask

    task automatic measure(input int n);
        int highs = 0;
        int ticks = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 8'd0, 1'b1);
            highs += int'(act_hi) + int'(act_lo);
            ticks += int'(act_tick);
        end
        chk("period_high_halves", 32'(highs), 32'(n));
        chk("ticks_per_period", 32'(ticks), 32'd1);
        chk("active_after_period", 32'(div_active_o), 32'(n));
        step(1'b0, 8'd0, 1'b1);
        chk("next_period_tick", 32'(act_tick), 32'd1);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        #1;
        chk("rst_clk_out", 32'(clk_out_o), 32'd0);
        chk("rst_tick", 32'(tick_o), 32'd0);
        chk("rst_div_active", 32'(div_active_o), 32'd5);
        chk("rst_div_err", 32'(div_err_o), 32'd0);
        model_reset();
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic en_v;
        int   r;
        logic [7:0] dn;

        //         ld  dn     hi lo tk act  err
        tbl[0]  = '{1'b0, 8'd0, 1, 1, 1, 8'd5, 0};
        tbl[1]  = '{1'b0, 8'd0, 1, 1, 0, 8'd5, 0};
        tbl[2]  = '{1'b0, 8'd0, 1, 0, 0, 8'd5, 0};
        tbl[3]  = '{1'b0, 8'd0, 0, 0, 0, 8'd5, 0};
        tbl[4]  = '{1'b0, 8'd0, 0, 0, 0, 8'd5, 0};
        tbl[5]  = '{1'b1, 8'd1, 1, 1, 1, 8'd5, 1};
        tbl[6]  = '{1'b1, 8'd0, 1, 1, 0, 8'd5, 1};
        tbl[7]  = '{1'b0, 8'd0, 1, 0, 0, 8'd5, 0};
        tbl[8]  = '{1'b1, 8'd4, 0, 0, 0, 8'd5, 0};
        tbl[9]  = '{1'b0, 8'd0, 0, 0, 0, 8'd5, 0};
        tbl[10] = '{1'b0, 8'd0, 1, 1, 1, 8'd4, 0};
        tbl[11] = '{1'b0, 8'd0, 1, 1, 0, 8'd4, 0};
        tbl[12] = '{1'b0, 8'd0, 0, 0, 0, 8'd4, 0};
        tbl[13] = '{1'b0, 8'd0, 0, 0, 0, 8'd4, 0};
        tbl[14] = '{1'b0, 8'd0, 1, 1, 1, 8'd4, 0};

        sys_rst_n  = 1'b0;
        div_n_i    = '0;
        div_load_i = 1'b0;
        en_r       = 1'b1;
        act_lo     = 1'b0;
        model_reset();
        #12;
        chk("reset_clk_out", 32'(clk_out_o), 32'd0);
        chk("reset_tick", 32'(tick_o), 32'd0);
        chk("reset_div_active", 32'(div_active_o), 32'd5);
        chk("reset_div_err", 32'(div_err_o), 32'd0);
        #1;
        sys_rst_n = 1'b1;

        // Default period, two illegal loads, then a mid-period switch to 4.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].ld, tbl[i].dn, 1'b1);
            chk("vec_clk_hi", 32'(act_hi), 32'(tbl[i].hi));
            chk("vec_clk_lo", 32'(act_lo), 32'(tbl[i].lo));
            chk("vec_tick", 32'(act_tick), 32'(tbl[i].tk));
            chk("vec_div_active", 32'(div_active_o), 32'(tbl[i].act));
            chk("vec_div_err", 32'(div_err_o), 32'(tbl[i].err));
        end

        // Two loads within one period: only the last one takes effect.
        step(1'b0, 8'd0, 1'b1);
        step(1'b1, 8'd7, 1'b1);
        step(1'b1, 8'd9, 1'b1);
        chk("active_before_apply", 32'(div_active_o), 32'd4);
        align();
        measure(9);

        // Extreme divisors.
        step(1'b1, 8'd2, 1'b1);
        align();
        measure(2);
        step(1'b1, 8'd255, 1'b1);
        align();
        measure(255);

        // Asynchronous reset while the output is high.
        for (int i = 0; i < 600 && act_lo !== 1'b1; i++) step(1'b0, 8'd0, 1'b1);
        do_reset();
        step(1'b0, 8'd0, 1'b1);
        chk("first_edge_tick", 32'(act_tick), 32'd1);
        chk("first_edge_high", 32'(act_hi), 32'd1);

`ifdef CLK_DIV_STOP_EN
        // Park, load while parked, restart.
        for (int i = 0; i < 8; i++) step(1'b0, 8'd0, 1'b0);
        step(1'b1, 8'd3, 1'b0);
        chk("parked_low", 32'(act_hi | act_lo), 32'd0);
        chk("parked_active", 32'(div_active_o), 32'd5);
        step(1'b0, 8'd0, 1'b1);
        chk("restart_tick", 32'(act_tick), 32'd1);
        chk("restart_high", 32'(act_hi), 32'd1);
        chk("restart_active", 32'(div_active_o), 32'd3);
`endif

        // Randomized loads (and run enable when present) against the slot model.
        en_v = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 15));
            dn = (r == 15) ? 8'($urandom_range(0, 255)) : 8'(r);
`ifdef CLK_DIV_STOP_EN
            if ($urandom_range(0, 19) == 0) en_v = ~en_v;
`endif
            step(($urandom_range(0, 7) == 0), dn, en_v);
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
